// File: rtl/alu_resp.sv
// alu_resp: registered 4-op ALU behind a valid/ready request port,
// returning in-order results through a 2-entry response buffer.
module alu_resp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_carry,
  output logic [1:0]       rsp_opcode,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             c;
    logic [WIDTH-1:0] y;
  } ent_t;

  st_t r_st;
  st_t w_nxt;
  ent_t r_hd;
  ent_t r_tl;
  ent_t w_new;
  logic w_push;
  logic w_pop;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic [CNT_W-1:0] r_cnt;

  assign req_ready  = (r_st != FULL);
  assign rsp_valid  = (r_st != EMPTY);
  assign w_push     = req_valid && req_ready;
  assign w_pop      = rsp_valid && rsp_ready;
  assign rsp_y      = r_hd.y;
  assign rsp_carry  = r_hd.c;
  assign rsp_opcode = r_hd.op;
  assign op_count   = r_cnt;

  // Extra top bit carries ADD carry-out / SUB borrow.
  assign w_sum = {1'b0, req_a} + {1'b0, req_b};
  assign w_dif = {1'b0, req_a} - {1'b0, req_b};

  always_comb begin
    w_new    = '0;
    w_new.op = req_opcode;
    unique case (req_opcode)
      2'b00: begin
        w_new.y = w_sum[WIDTH-1:0];
        w_new.c = w_sum[WIDTH];
      end
      2'b01: begin
        w_new.y = w_dif[WIDTH-1:0];
        w_new.c = w_dif[WIDTH];
      end
      2'b10: w_new.y = ~req_a;
      2'b11: w_new.y = req_a | req_b;
    endcase
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      EMPTY: if (w_push) w_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_nxt = FULL;
        else if (w_pop && !w_push) w_nxt = EMPTY;
      end
      FULL: if (w_pop) w_nxt = ONE;
      default: w_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= EMPTY;
    else        r_st <= w_nxt;
  end

  // Head holds its last value when popped to empty, so outputs never go X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hd <= '0;
      r_tl <= '0;
    end else begin
      unique case (1'b1)
        (r_st == FULL): begin
          if (w_pop) r_hd <= r_tl;
        end
        (r_st == ONE): begin
          if (w_push && w_pop) r_hd <= w_new;
          else if (w_push)     r_tl <= w_new;
        end
        default: begin
          if (w_push) r_hd <= w_new;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_resp.sv
// tb_alu_resp: directed plus random stimulus for alu_resp, checked
// cycle by cycle against a queue-based reference model.
module tb_alu_resp;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_opcode = 2'b00;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_y;
  logic          rsp_carry;
  logic [1:0]    rsp_opcode;
  logic [CW-1:0] op_count;

  alu_resp #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_carry  (rsp_carry),
    .rsp_opcode (rsp_opcode),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int y;
    int c;
  } rsp_t;

  rsp_t q[$];
  int   pops[$];
  int   cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t ref_op(input int op, input int a, input int b);
    rsp_t r;
    int   m;
    m    = 1 << W;
    r.op = op;
    r.c  = 0;
    case (op)
      0: begin
        r.y = (a + b) % m;
        r.c = (a + b >= m) ? 1 : 0;
      end
      1: begin
        r.y = (a - b + m) % m;
        r.c = (a < b) ? 1 : 0;
      end
      2: r.y = (m - 1) - a;
      default: r.y = a | b;
    endcase
    return r;
  endfunction

  task automatic post_chk();
    chk("valid", rsp_valid, q.size() != 0);
    chk("ready", req_ready, q.size() < 2);
    chk("count", op_count, cnt);
    if (q.size() != 0) begin
      chk("head_y", rsp_y, q[0].y);
      chk("head_c", rsp_carry, q[0].c);
      chk("head_op", rsp_opcode, q[0].op);
    end
  endtask

  task automatic cyc(input bit v, input int op, input int a,
                     input int b, input bit rr);
    bit   pop;
    rsp_t n;
    @(negedge clk);
    req_valid  = v;
    req_opcode = op[1:0];
    req_a      = a[W-1:0];
    req_b      = b[W-1:0];
    rsp_ready  = rr;
    #1;
    chk("pre_ready", req_ready, q.size() < 2);
    last_acc = v && (q.size() < 2);
    pop      = rr && (q.size() != 0);
    if (pop) pops.push_back({rsp_carry, rsp_y});
    n = ref_op(op, a, b);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      cnt = (cnt + 1) % (1 << CW);
    end
    if (last_acc) q.push_back(n);
    post_chk();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nacc;
    int c0;
    // reset state
    #12;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_y", rsp_y, 0);
    chk("rst_c", rsp_carry, 0);
    chk("rst_op", rsp_opcode, 0);
    chk("rst_cnt", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: four ops back-to-back, rsp_ready held
    pops.delete();
    for (int i = 0; i < 4; i++) cyc(1, i, 8'h0F, 8'hF0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_n", pops.size(), 4);
    if (pops.size() == 4) begin
      chk("t1_add", pops[0], 9'h0FF);
      chk("t1_sub", pops[1], 9'h11F);
      chk("t1_inv", pops[2], 9'h0F0);
      chk("t1_orr", pops[3], 9'h0FF);
    end
    chk("t1_cnt", op_count, 4);

    // 2: carry/borrow edges
    pops.delete();
    cyc(1, 0, 8'hFF, 8'h01, 1);
    cyc(1, 1, 8'h05, 8'h05, 1);
    cyc(1, 1, 8'h00, 8'h01, 1);
    cyc(1, 2, 8'h00, 8'hAA, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_n", pops.size(), 4);
    if (pops.size() == 4) begin
      chk("t2_add", pops[0], 9'h100);
      chk("t2_sub0", pops[1], 9'h000);
      chk("t2_subb", pops[2], 9'h1FF);
      chk("t2_inv", pops[3], 9'h0FF);
    end

    // 3: backpressure
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 16 + i, 1, 0);
      if (last_acc) nacc++;
    end
    chk("t3_acc", nacc, 2);
    chk("t3_rdy0", req_ready, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_rdy1", req_ready, 1);
    drain();

    // 4: push and pop together in ONE
    cyc(1, 3, 8'h30, 8'h03, 0);
    c0 = op_count;
    for (int i = 0; i < 3; i++) cyc(1, i, 8'h40 + i, 8'h11, 1);
    chk("t4_cnt", op_count, (c0 + 3) % 16);
    chk("t4_one", {rsp_valid, req_ready}, 2'b11);
    drain();

    // 5: async reset while FULL, mid-cycle
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 2, 2, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", rsp_valid, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_cnt", op_count, 0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pops.delete();
    cyc(1, 0, 8'h01, 8'h02, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t5_n", pops.size(), 1);
    if (pops.size() == 1) chk("t5_add", pops[0], 9'h003);

    // 6: counter wrap
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 0, i, i, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_15", op_count, 15);
    cyc(1, 2, 8'h5A, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_wrap", op_count, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 3) != 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_resp.md
Name: alu_resp

Overview:
Sequential responder for the 4-opcode ALU command interface (ADD/SUB/INV/ORR).
- Accepts operand/opcode requests over a valid/ready handshake.
- Computes a registered result and carry/borrow flag.
- Returns them in order through a 2-entry response buffer with backpressure.
- Sits behind any initiator that issues ALU ops, replacing the purely combinational ALU where a pipelined, flow-controlled datapath is required.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_opcode  in  2  00=ADD, 01=SUB, 10=INV, 11=ORR
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
rsp_valid  out  1  response present at buffer head
rsp_ready  in  1  consumer accepts response
rsp_y  out  WIDTH  result at head
rsp_carry  out  1  ADD carry-out / SUB borrow at head; 0 for INV/ORR
rsp_opcode  out  2  opcode of head response
op_count  out  CNT_W  number of completed response handshakes, wraps

Behaviour:
- Reset (async assert, sync release on clk):
  - buffer emptied; rsp_valid=0; rsp_y=0; rsp_carry=0; rsp_opcode=00; op_count=0; req_ready=1 after reset.
  - Reset mid-operation discards all buffered responses; no partial handshake is completed.
- Request handshake: accept when req_valid && req_ready at a rising edge.
  - Inputs are sampled only at that edge.
  - req_opcode, req_a and req_b may change freely when not accepted.
- Arithmetic (computed from the accepted sample, written into the buffer at the same edge):
  - ADD: {carry,y} = A + B in WIDTH+1 bits.
  - SUB: y = (A - B) mod 2^WIDTH; carry = 1 if A < B (unsigned borrow), else 0.
  - INV: y = ~A; B ignored; carry = 0.
  - ORR: y = A | B; carry = 0.
- Response buffer: 2-entry in-order FIFO. States are EMPTY, ONE and FULL.
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on simultaneous push and pop (new entry becomes head next cycle).
  - FULL -> ONE on pop.
  - FULL cannot push.
- req_ready = not FULL. It is a registered-state decode and does not depend on rsp_ready (no combinational ready path).
- rsp_valid = not EMPTY. rsp_y, rsp_carry and rsp_opcode always reflect the head entry. Their values are don't-care when EMPTY but must hold the last popped values (no X).
- Pop occurs when rsp_valid && rsp_ready at a rising edge.
- While rsp_valid=1 and rsp_ready=0, the head fields must stay stable.
- Latency: a request accepted at edge N into an EMPTY buffer gives rsp_valid=1 with the result from edge N until popped. That is one cycle request-to-response.
- Throughput: with rsp_ready held 1, one op per cycle sustained and req_ready stays 1.
- op_count increments by 1 on each response pop and wraps from 2^CNT_W-1 to 0.
- Opcode values are all legal; there is no error path.

Test Plan:
1. Reset, then A=0x0F, B=0xF0, ops ADD, SUB, INV, ORR back-to-back with rsp_ready=1:
   - responses are 0xFF/c0, 0x1F/c1, 0xF0/c0, 0xFF/c0 in order.
   - rsp_valid first rises one cycle after the first accept.
   - op_count ends at 4.
2. Carry/borrow edges:
   - ADD 0xFF+0x01 -> 0x00 c1.
   - SUB 0x05-0x05 -> 0x00 c0.
   - SUB 0x00-0x01 -> 0xFF c1.
   - INV A=0x00 with B=0xAA -> 0xFF c0.
3. Backpressure with rsp_ready=0 and req_valid held 1 for 4 cycles:
   - exactly 2 requests accepted, then req_ready=0.
   - head fields remain stable.
   - raising rsp_ready for 1 cycle pops one and req_ready returns 1 on the next cycle.
4. Simultaneous push and pop in state ONE, three times:
   - stays ONE, responses remain in order, no loss or duplication.
   - op_count advances by exactly 1 per pop.
5. Assert rst_n low asynchronously while FULL and mid-cycle:
   - rsp_valid=0 and req_ready=1 immediately.
   - op_count=0.
   - after release, a single ADD 0x01+0x02 returns 0x03.
6. Preload op_count near wrap (CNT_W=4, 15 pops), then one more pop -> op_count=0.
